// File: rtl/serial_frame_tx.sv
// serial_frame_tx: valid/ready word in, one bit per clock out (bit_out/bit_valid), zero gap after each frame, busy and frame_done status
module serial_frame_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic busy_q, busy_d, frame_done_q, frame_done_d;
  logic last_bit, last_gap;
  assign shifted    = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
  assign last_bit   = bcnt_q == BW'(WIDTH);
  assign last_gap   = gcnt_q == GW'(GAP_CYCLES);
  assign data_ready = reset && state_q == IDLE;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bcnt_d       = bcnt_q;
    gcnt_d       = gcnt_q;
    bit_out_d    = 1'b0;
    bit_valid_d  = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: if (data_valid) begin
        state_d     = SHIFT;
        shreg_d     = data_in;
        bcnt_d      = BW'(1);
        bit_out_d   = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
        bit_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      SHIFT: if (last_bit) begin
        if (GAP_CYCLES > 0) state_d = GAP;
        else state_d = IDLE;
        bcnt_d       = '0;
        gcnt_d       = GW'(1);
        busy_d       = GAP_CYCLES > 0;
        frame_done_d = 1'b1;
      end else begin
        shreg_d     = shifted;
        bcnt_d      = bcnt_q + BW'(1);
        bit_out_d   = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
        bit_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      GAP: if (last_gap) begin
        state_d = IDLE;
        gcnt_d  = '0;
      end else begin
        gcnt_d = gcnt_q + GW'(1);
        busy_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bcnt_q       <= '0;
      gcnt_q       <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bcnt_q       <= bcnt_d;
      gcnt_q       <= gcnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: three serial_frame_tx variants (default, LSB-first, zero gap) checked against a frame-offset model
module tb_serial_frame_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] rdy, bo, bv, by, fd;
  int ntest = 0;
  int nfail = 0;
  int cyc = 0;
  int acc [3] = '{-100000, -100000, -100000};
  logic [7:0] wd [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] g0, g1;
  logic [18:0] s;
  logic [17:0] f;
  typedef struct { logic [7:0] d; logic [7:0] s0; logic [7:0] s1; } vec_t;
  vec_t vt [5];
  always #5 clk = ~clk;
  serial_frame_tx u0 (.clock(clk), .reset(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy[0]), .bit_out(bo[0]), .bit_valid(bv[0]), .busy(by[0]), .frame_done(fd[0]));
  serial_frame_tx #(.MSB_FIRST(1'b0)) u1 (.clock(clk), .reset(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy[1]), .bit_out(bo[1]), .bit_valid(bv[1]), .busy(by[1]), .frame_done(fd[1]));
  serial_frame_tx #(.GAP_CYCLES(0)) u2 (.clock(clk), .reset(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy[2]), .bit_out(bo[2]), .bit_valid(bv[2]), .busy(by[2]), .frame_done(fd[2]));
  function automatic int gap_of(int k);
    return k == 2 ? 0 : 2;
  endfunction
  function automatic logic [4:0] model(int k);
    int o = cyc - acc[k];
    logic b = 1'b0;
    if (o >= 1 && o <= 8) b = k == 1 ? wd[k][o-1] : wd[k][8-o];
    return {rst_n && o > 8 + gap_of(k), b, o >= 1 && o <= 8, o >= 1 && o <= 8 + gap_of(k), o == 9};
  endfunction
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    ntest++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) acc[k] = -100000;
    end else begin
      for (int k = 0; k < 3; k++)
        if (data_valid && cyc - acc[k] > 8 + gap_of(k)) begin
          acc[k] = cyc;
          wd[k] = data_in;
        end
      cyc++;
    end
  end
  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      check($sformatf("model u%0d", k), {rdy[k], bo[k], bv[k], by[k], fd[k]}, model(k));
  initial begin
    vt[0] = '{8'hA5, 8'hA5, 8'hA5};
    vt[1] = '{8'h01, 8'h01, 8'h80};
    vt[2] = '{8'h3C, 8'h3C, 8'h3C};
    vt[3] = '{8'hF0, 8'hF0, 8'h0F};
    vt[4] = '{8'h00, 8'h00, 8'h00};
    repeat (3) @(negedge clk);
    check("reset outputs", {rdy, bo, bv, by, fd}, 15'b0);
    #2 rst_n = 1'b1;
    #1 check("ready after reset", rdy, 3'b111);
    for (int i = 0; i < 5; i++) begin
      repeat (12) @(negedge clk);
      data_in = vt[i].d;
      data_valid = 1'b1;
      g0 = '0;
      g1 = '0;
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        data_valid = 1'b0;
        g0 = {g0[6:0], bo[0]};
        g1 = {g1[6:0], bo[1]};
      end
      check($sformatf("msb seq %h", vt[i].d), g0, vt[i].s0);
      check($sformatf("lsb seq %h", vt[i].d), g1, vt[i].s1);
      @(negedge clk);
      check("gap1 u0", {bo[0], bv[0], by[0], fd[0]}, 4'b0011);
      @(negedge clk);
      check("gap2 u0", {bo[0], bv[0], by[0], fd[0]}, 4'b0010);
      @(negedge clk);
      check("idle u0", {rdy[0], by[0], fd[0]}, 3'b100);
    end
    repeat (12) @(negedge clk);
    data_in = 8'h3C;
    data_valid = 1'b1;
    s = '0;
    for (int j = 0; j < 19; j++) begin
      @(negedge clk);
      if (j == 0) data_in = 8'hFF;
      s = {s[17:0], bo[0]};
    end
    data_valid = 1'b0;
    check("hold stream", s, 19'b0011110000011111111);
    repeat (12) @(negedge clk);
    data_in = 8'h81;
    data_valid = 1'b1;
    s = '0;
    f = '0;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (j < 17) s = {s[17:0], bo[2]};
      f = {f[16:0], fd[2]};
    end
    data_valid = 1'b0;
    check("gap0 stream", s[16:0], 17'b10000001010000001);
    check("gap0 done", f, 18'b000000001000000001);
    repeat (12) @(negedge clk);
    data_in = 8'hF0;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 check("bit4 before abort", {bo[0], bv[0], by[0]}, 3'b111);
    #1 rst_n = 1'b0;
    #1 check("abort outputs", {rdy, bo, bv, by, fd}, 15'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready after abort", rdy, 3'b111);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      data_in = 8'($urandom);
      data_valid = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    data_valid = 1'b0;
    repeat (15) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Upstream feeder for the serial sequence-detector FSM. It accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock on a single serial line, which drives the detector's `in` port. Each frame is followed by a programmable idle gap of zeros, so the detector sees a clean inter-frame stream. The block also gives the bench and top level frame-level status: busy, and a done pulse.

Parameters:
WIDTH, 8, bits per frame; legal range 2..32.
GAP_CYCLES, 2, zero-level idle cycles inserted after each frame; 0 is legal.
MSB_FIRST, 1, 1 = data_in[WIDTH-1] is sent first; 0 = data_in[0] is sent first.

Ports:
clock  input  1  rising-edge system clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
data_in  input  WIDTH  parallel word to serialise; sampled on accept
data_valid  input  1  producer has a word on data_in
data_ready  output  1  block can accept a word this cycle
bit_out  output  1  serial data line; drives the detector's `in`
bit_valid  output  1  1 while bit_out carries a frame bit
busy  output  1  1 from accept until the last gap cycle ends
frame_done  output  1  one-cycle pulse in the first cycle after the last frame bit

Behaviour:
- Reset:
  - reset low forces state IDLE, shift register to 0, bit counter to 0, gap counter to 0.
  - Outputs during reset: bit_out=0, bit_valid=0, busy=0, frame_done=0.
  - data_ready is gated to 0 while reset is low.
  - The first accept is possible on the first rising edge after reset deasserts.
- State machine: IDLE, SHIFT, GAP.
- IDLE:
  - data_ready=1, bit_out=0, bit_valid=0, busy=0.
  - On an edge with data_valid=1, capture data_in (accept) and go to SHIFT.
- SHIFT:
  - The first bit appears after the accept edge (1-cycle latency); bit_valid=1.
  - Bits advance one per edge; exactly WIDTH bit cycles are sent.
  - Bit order is set by MSB_FIRST.
  - After the WIDTH-th bit cycle: go to GAP if GAP_CYCLES>0, else to IDLE.
- GAP:
  - bit_out=0, bit_valid=0, busy=1 for exactly GAP_CYCLES cycles, then IDLE.
- frame_done: asserted for exactly one cycle, the cycle immediately after the last SHIFT cycle (first GAP cycle, or first IDLE cycle when GAP_CYCLES=0).
- busy: 1 in SHIFT and GAP, 0 in IDLE.
- data_ready is 0 outside IDLE. data_valid and data_in are ignored while busy; nothing is queued.
- Back-to-back frames when GAP_CYCLES=0:
  - The earliest next accept is the edge ending the first IDLE cycle.
  - That leaves exactly one 0 cycle with bit_valid=0 between frames.
- Counters:
  - The bit counter is sized $clog2(WIDTH+1) and never wraps within a frame.
  - The gap counter is sized $clog2(GAP_CYCLES+1), with a minimum of 1 bit.
- Reset asserted mid-frame: the frame is aborted immediately. No frame_done; bit_out returns to 0 asynchronously.
- All outputs except data_ready are registered; data_ready is decoded from state and gated by reset.
- No X on any output after reset, for any data_in value.

Test Plan:
- Reset, then data_in=8'hA5 with data_valid=1 for one cycle (defaults):
  - bit_out on the 8 cycles after accept is 1,0,1,0,0,1,0,1 with bit_valid=1.
  - Then 2 cycles of 0 with bit_valid=0; frame_done high in gap cycle 1 only.
  - busy high for 10 cycles; data_ready returns to 1 on cycle 11.
- MSB_FIRST=0, data_in=8'hA5: bit_out sequence is 1,0,1,0,0,1,0,1.
  - This is palindromic, so also run 8'h01: sequence 1,0,0,0,0,0,0,0.
- data_valid held high with data_in changing during SHIFT (8'h3C accepted, 8'hFF presented mid-frame):
  - Only 8'h3C is sent: 0,0,1,1,1,1,0,0.
  - 8'hFF is accepted only once the block is back in IDLE.
- Reset pulled low on the 4th bit of frame 8'hF0:
  - bit_out=0, bit_valid=0, busy=0 immediately; no frame_done.
  - data_ready=1 on the first cycle after release.
- GAP_CYCLES=0, data_valid held high with 8'h81 then 8'h81:
  - Stream is 1,0,0,0,0,0,0,1,0,1,0,0,0,0,0,0,1; exactly one idle 0 between frames.
  - frame_done pulses twice, 9 cycles apart.
- Chained with the detector on the defaults: feed 8'h00 and confirm the detector's `out` stays 0 for the whole frame and gap.
